// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Optional feature macro: BCD_BINARY_DIGIT_CHECK_EN (operand digit check, err port).
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ADJUST = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DIGITS_DEF = 4;
  localparam int BIN_W_DEF  = 14;

  // Reverse double-dabble correction: a nibble of 8 or more after a right
  // shift carried a "ten" in from above and must drop by 3.
  localparam logic [3:0] NIB_8 = 4'd8;
  localparam logic [3:0] NIB_3 = 4'd3;
  // Largest legal BCD digit.
  localparam logic [3:0] NIB_9 = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit reverse double-dabble correction cell (combinational).
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= NIB_8) ? (d_i - NIB_3) : d_i;

endmodule

// File: rtl/bcd_binary.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One bit of the result is produced per SHIFT/ADJUST pair, so a conversion
// takes 2*BIN_W+1 edges from the start edge to the result edge.
// Optional feature macro: BCD_BINARY_DIGIT_CHECK_EN adds the err output,
// which flags an operand nibble above 9 and forces the result to 0.
module bcd_binary
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd,
  output logic [BIN_W-1:0]    binary,
  output logic                valid,
  output logic                busy
`ifdef BCD_BINARY_DIGIT_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  // The result register must hold the largest DIGITS-digit decimal value.
  if (2**BIN_W < 10**DIGITS) begin : g_width_check
    $error("bcd_binary: BIN_W is too narrow for DIGITS decimal digits");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [WORK_W-1:0] work_q,  work_d;   // {bcd_reg, bin_reg}
  logic [BIN_W-1:0]  binary_q, binary_d;
  logic              valid_q, valid_d;

  logic [BCD_W-1:0]  adj_bcd;
  logic [BIN_W-1:0]  result;

  // All BCD digits are corrected in parallel, one cell per digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_i (work_q[BIN_W + 4*g +: 4]),
      .d_o (adj_bcd[4*g +: 4])
    );
  end

`ifdef BCD_BINARY_DIGIT_CHECK_EN
  logic bad_digit;
  logic bad_q;
  logic err_q;

  // Detect any operand nibble outside 0..9.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > NIB_9) bad_digit = 1'b1;
    end
  end

  // Latch the check at load; publish it together with the result at DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) bad_q <= bad_digit;
      if (state_q == DONE)          err_q <= bad_q;
    end
  end

  // A malformed operand still runs the full latency but reports zero.
  assign result = bad_q ? '0 : work_q[BIN_W-1:0];
  assign err    = err_q;
`else
  assign result = work_q[BIN_W-1:0];
`endif

  // Next-state logic for the FSM, iteration counter and working register.
  always_comb begin
    // NOTE: every next-state signal is defaulted before the case, so no path
    // leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    binary_d = binary_q;
    valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {bcd, {BIN_W{1'b0}}};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = {1'b0, work_q[WORK_W-1:1]};
        state_d = ADJUST;
      end
      ADJUST: begin
        work_d  = {adj_bcd, work_q[BIN_W-1:0]};
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q < CNT_W'(BIN_W - 1)) ? SHIFT : DONE;
      end
      DONE: begin
        binary_d = result;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      binary_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      binary_q <= binary_d;
      valid_q  <= valid_d;
    end
  end

  assign binary = binary_q;
  assign valid  = valid_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_binary.sv
// Directed self-checking bench for bcd_binary, plus an exhaustive 0000..9999
// sweep spread across parallel lanes. Digit-check vectors are compiled in
// when BCD_BINARY_DIGIT_CHECK_EN is defined.
module tb_bcd_binary;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = 2 * BIN_W + 1;
  localparam int LANES  = 10;
  localparam int PER_LANE = 1000;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [15:0]       bcd;
  logic [BIN_W-1:0]  binary;
  logic              valid;
  logic              busy;
`ifdef BCD_BINARY_DIGIT_CHECK_EN
  logic              err;
`endif

  logic              sw_start;
  logic [15:0]       sw_bcd   [LANES];
  logic [BIN_W-1:0]  sw_bin   [LANES];
  logic              sw_valid [LANES];
  logic              sw_busy  [LANES];
`ifdef BCD_BINARY_DIGIT_CHECK_EN
  logic              sw_err   [LANES];
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bcd    (bcd),
    .binary (binary),
    .valid  (valid),
    .busy   (busy)
`ifdef BCD_BINARY_DIGIT_CHECK_EN
    ,
    .err    (err)
`endif
  );

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bcd_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_sw (
      .clk    (clk),
      .reset  (reset),
      .start  (sw_start),
      .bcd    (sw_bcd[l]),
      .binary (sw_bin[l]),
      .valid  (sw_valid[l]),
      .busy   (sw_busy[l])
`ifdef BCD_BINARY_DIGIT_CHECK_EN
      ,
      .err    (sw_err[l])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the start edge until valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid && n < 100);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // {valid, busy, err, binary} of one sweep lane, for a single comparison.
  function automatic logic [31:0] lane_obs(input int l);
    logic e;
`ifdef BCD_BINARY_DIGIT_CHECK_EN
    e = sw_err[l];
`else
    e = 1'b0;
`endif
    return 32'({sw_valid[l], sw_busy[l], e, sw_bin[l]});
  endfunction

  initial begin
    int n;
    int nv;
    int first;
    int bad;
    logic [BIN_W-1:0] cap;

    reset    = 1'b1;
    start    = 1'b0;
    bcd      = '0;
    sw_start = 1'b0;
    for (int l = 0; l < LANES; l++) sw_bcd[l] = '0;
    repeat (2) tick();

    check("rst_binary", 32'(binary), 0);
    check("rst_valid",  32'(valid),  0);
    check("rst_busy",   32'(busy),   0);
`ifdef BCD_BINARY_DIGIT_CHECK_EN
    check("rst_err",    32'(err),    0);
`endif
    reset = 1'b0;
    tick();

    // 9999: latency, value, busy profile.
    bcd = 16'h9999; start = 1'b1; tick(); start = 1'b0;
    check("busy_run", 32'(busy), 1);
    wait_valid(n);
    check("lat_9999",      n,            LAT);
    check("bin_9999",      32'(binary),  9999);
    check("busy_at_valid", 32'(busy),    0);

    // 0000, then 8191 started in the valid cycle.
    bcd = 16'h0000; start = 1'b1; tick(); start = 1'b0;
    wait_valid(n);
    check("lat_0000", n,           LAT);
    check("bin_0000", 32'(binary), 0);
    bcd = 16'h8191; start = 1'b1; tick(); start = 1'b0;
    check("valid_width", 32'(valid), 0);
    check("b2b_busy",    32'(busy),  1);
    wait_valid(n);
    check("lat_b2b",  n,           LAT);
    check("bin_8191", 32'(binary), 8191);

    // Start while busy is ignored.
    bcd = 16'h1234; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    bcd = 16'h5678; start = 1'b1; tick(); start = 1'b0;
    check("ign_busy", 32'(busy), 1);
    nv = 0; first = 0; cap = '0;
    for (int c = 6; c <= 80; c++) begin
      tick();
      if (valid) begin
        nv++;
        cap = binary;
        if (first == 0) first = c;
      end
    end
    check("ign_valid_cnt", nv,       1);
    check("ign_bin",       32'(cap), 1234);
    check("ign_lat",       first,    LAT);

    // Reset at cycle 10 aborts 4321.
    bcd = 16'h4321; start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    #1;
    check("abort_binary", 32'(binary), 0);
    check("abort_valid",  32'(valid),  0);
    check("abort_busy",   32'(busy),   0);
`ifdef BCD_BINARY_DIGIT_CHECK_EN
    check("abort_err",    32'(err),    0);
`endif
    bcd = 16'h0042; start = 1'b1;
    tick(); tick();
    check("rst_start_ign", 32'(busy), 0);
    reset = 1'b0;
    tick();
    start = 1'b0;
    check("post_rst_busy", 32'(busy), 1);
    bad = 0; n = 0;
    do begin
      if (binary !== '0) bad++;
      tick();
      n++;
    end while (!valid && n < 100);
    check("abort_hold", bad,          0);
    check("lat_0042",   n,            LAT);
    check("bin_0042",   32'(binary),  42);

`ifdef BCD_BINARY_DIGIT_CHECK_EN
    // Illegal nibble flagged, result forced to zero, then recovery.
    bcd = 16'h12A4; start = 1'b1; tick(); start = 1'b0;
    wait_valid(n);
    check("lat_12a4", n,           LAT);
    check("err_12a4", 32'(err),    1);
    check("bin_12a4", 32'(binary), 0);
    bcd = 16'h0010; start = 1'b1; tick(); start = 1'b0;
    wait_valid(n);
    check("err_0010", 32'(err),    0);
    check("bin_0010", 32'(binary), 10);
`endif

    // Exhaustive sweep: lane l converts l*1000+k, all lanes in lockstep.
    for (int k = 0; k < PER_LANE; k++) begin
      for (int l = 0; l < LANES; l++) sw_bcd[l] = to_bcd(l * PER_LANE + k);
      sw_start = 1'b1; tick(); sw_start = 1'b0;
      n = 0;
      do begin
        tick();
        n++;
      end while (!sw_valid[0] && n < 100);
      for (int l = 0; l < LANES; l++) begin
        check("sweep", lane_obs(l), 32'((1 << 16) | (l * PER_LANE + k)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
